// File: rtl/mochila_ram_arbiter.sv
// mochila_ram_arbiter: round-robin OBI N:1 arbiter in front of the shared RAM port,
// with an in-order routing FIFO that steers each RAM response back to its requester.

`default_nettype none

package mochila_obi_pkg;
    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;
endpackage

module mochila_ram_arbiter
    import mochila_obi_pkg::*;
#(
    parameter int NMASTERS        = 3,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  obi_req_t  [NMASTERS-1:0] master_req_i,
    output obi_resp_t [NMASTERS-1:0] master_resp_o,
    output obi_req_t                 slave_req_o,
    input  obi_resp_t                slave_resp_i
);

    localparam int IDX_W = $clog2(NMASTERS);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NMASTERS - 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [IDX_W-1:0] rr_ptr;
    logic             lock_valid;
    logic [IDX_W-1:0] lock_idx;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [IDX_W-1:0] fifo_mem [MAX_OUTSTANDING];

    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] scan;
    logic             found;
    logic             full;
    logic             fwd_req;
    logic             handshake;
    logic             pop;
    logic [IDX_W-1:0] head;

    // Scan starting at rr_ptr; a pending (ungranted) request pins the winner.
    always_comb begin
        winner = rr_ptr;
        found  = 1'b0;
        scan   = rr_ptr;
        for (int i = 0; i < NMASTERS; i++) begin
            if (!found && master_req_i[scan].req) begin
                winner = scan;
                found  = 1'b1;
            end
            scan = (scan == LAST_IDX) ? '0 : scan + 1'b1;
        end
        if (lock_valid) begin
            winner = lock_idx;
        end
    end

    // Full blocks new requests even when an rvalid frees a slot this cycle.
    assign full      = (count == FULL_CNT);
    assign fwd_req   = !rst_i && master_req_i[winner].req && !full;
    assign handshake = fwd_req && slave_resp_i.gnt;
    assign pop       = !rst_i && slave_resp_i.rvalid && (count != '0);
    assign head      = fifo_mem[rd_ptr];

    always_comb begin
        slave_req_o     = master_req_i[winner];
        slave_req_o.req = fwd_req;
    end

    always_comb begin
        for (int m = 0; m < NMASTERS; m++) begin
            master_resp_o[m]     = '0;
            master_resp_o[m].gnt = handshake && (winner == IDX_W'(m));
            if (pop && (head == IDX_W'(m))) begin
                master_resp_o[m].rvalid = 1'b1;
                master_resp_o[m].rdata  = slave_resp_i.rdata;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr     <= '0;
            lock_valid <= 1'b0;
            lock_idx   <= '0;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            if (handshake) begin
                rr_ptr     <= (winner == LAST_IDX) ? '0 : winner + 1'b1;
                lock_valid <= 1'b0;
                wr_ptr     <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end else if (fwd_req) begin
                lock_valid <= 1'b1;
                lock_idx   <= winner;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({handshake, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (handshake) begin
            fifo_mem[wr_ptr] <= winner;
        end
    end

    // An rvalid with nothing outstanding is dropped; flag it in simulation.
    a_rvalid_with_outstanding: assert property (
        @(posedge clk_i) disable iff (rst_i)
        !(slave_resp_i.rvalid && (count == '0))
    ) else $error("rvalid received with no outstanding transaction");

endmodule

`default_nettype wire

// File: tb/tb_mochila_ram_arbiter.sv
// Scoreboard bench for mochila_ram_arbiter: RAM model answers one cycle after grant,
// expected responses are queued as stimulus is driven and compared against routed rvalids.

`default_nettype none

module tb_mochila_ram_arbiter;
    import mochila_obi_pkg::*;

    localparam int NM = 3;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } resp_rec_t;

    logic                   clk = 1'b0;
    logic                   rst;
    obi_req_t  [NM-1:0]     mreq;
    obi_resp_t [NM-1:0]     mresp;
    obi_req_t               sreq;
    obi_resp_t              sresp;

    int          checks = 0;
    int          errors = 0;
    int          n_req [NM];
    bit          ram_gnt;
    bit          rv_hold;
    logic [31:0] pending [$];
    resp_rec_t   sb [$];
    resp_rec_t   obs [$];

    int          g, r;
    logic        sv;
    logic [31:0] sa, ro;

    always #5 clk = ~clk;

    mochila_ram_arbiter #(
        .NMASTERS       (NM),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .master_req_i (mreq),
        .master_resp_o(mresp),
        .slave_req_o  (sreq),
        .slave_resp_i (sresp)
    );

    function automatic logic [31:0] addr_of(input int m);
        return 32'h1000 + 32'(m) * 32'h100;
    endfunction

    function automatic int oh(input logic [NM-1:0] v);
        int k = -1;
        for (int i = 0; i < NM; i++) if (v[i]) k = (k == -1) ? i : -2;
        return k;
    endfunction

    function automatic void expect_resp(input int m);
        resp_rec_t e;
        e.idx  = m;
        e.data = 32'h100 + 32'(m);
        sb.push_back(e);
    endfunction

    // One clock: drive masters, sample at negedge, then act as the RAM after the edge.
    task automatic cycle(output int go, output int ro_idx, output logic sreq_v,
                         output logic [31:0] saddr, output logic [31:0] rdata_or);
        logic [NM-1:0] gv, rv;
        logic          acc;
        logic [31:0]   acc_addr;
        resp_rec_t     o;
        for (int m = 0; m < NM; m++) begin
            mreq[m].req   = (n_req[m] > 0);
            mreq[m].addr  = addr_of(m);
            mreq[m].we    = 1'b0;
            mreq[m].be    = 4'hF;
            mreq[m].wdata = 32'h0;
        end
        sresp.gnt = ram_gnt;
        @(negedge clk);
        rdata_or = 32'h0;
        for (int m = 0; m < NM; m++) begin
            gv[m] = mresp[m].gnt;
            rv[m] = mresp[m].rvalid;
            rdata_or = rdata_or | mresp[m].rdata;
        end
        go     = oh(gv);
        ro_idx = oh(rv);
        if (ro_idx != -1) begin
            o.idx  = ro_idx;
            o.data = (ro_idx >= 0) ? mresp[ro_idx].rdata : 32'h0;
            obs.push_back(o);
        end
        sreq_v   = sreq.req;
        saddr    = sreq.addr;
        acc      = sreq.req && ram_gnt;
        acc_addr = sreq.addr;
        @(posedge clk);
        #1;
        if (go >= 0 && n_req[go] > 0) n_req[go]--;
        if (acc) pending.push_back(32'h100 + {28'h0, acc_addr[11:8]});
        if (!rv_hold && pending.size() > 0) begin
            sresp.rvalid = 1'b1;
            sresp.rdata  = pending.pop_front();
        end else begin
            sresp.rvalid = 1'b0;
            sresp.rdata  = 32'h0;
        end
    endtask

    task automatic drain();
        for (int m = 0; m < NM; m++) n_req[m] = 0;
        ram_gnt = 1'b1;
        rv_hold = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cycle(g, r, sv, sa, ro);
            if (pending.size() == 0 && !sresp.rvalid) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int m = 0; m < NM; m++) n_req[m] = 0;
        ram_gnt = 1'b0;
        rv_hold = 1'b1;
        sresp   = '0;
        cycle(g, r, sv, sa, ro);
        cycle(g, r, sv, sa, ro);
        rst = 1'b0;
        cycle(g, r, sv, sa, ro);
        checks++; if (sv !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b, expected 0", sv); end
        checks++; if (g != -1) begin errors++; $display("FAIL reset_gnt: got %0d, expected -1", g); end
        checks++; if (r != -1) begin errors++; $display("FAIL reset_rvalid: got %0d, expected -1", r); end
        checks++; if (ro !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h, expected 0", ro); end
    endtask

    task automatic test_round_robin();
        int exp_g [6] = '{0, 1, 2, 0, 1, 2};
        for (int m = 0; m < NM; m++) n_req[m] = 2;
        ram_gnt = 1'b1;
        rv_hold = 1'b0;
        for (int k = 0; k < 6; k++) begin
            expect_resp(exp_g[k]);
            cycle(g, r, sv, sa, ro);
            checks++;
            if (g != exp_g[k]) begin errors++; $display("FAIL rr_grant[%0d]: got %0d, expected %0d", k, g, exp_g[k]); end
        end
        drain();
        checks++;
        if (obs.size() != sb.size()) begin errors++; $display("FAIL rr_resp_count: got %0d, expected %0d", obs.size(), sb.size()); end
        while (sb.size() > 0 && obs.size() > 0) begin
            resp_rec_t e = sb.pop_front();
            resp_rec_t o = obs.pop_front();
            checks++;
            if (o.idx != e.idx || o.data !== e.data) begin
                errors++; $display("FAIL rr_resp: got m%0d %h, expected m%0d %h", o.idx, o.data, e.idx, e.data);
            end
        end
        sb.delete(); obs.delete();
    endtask

    task automatic test_lock();
        ram_gnt  = 1'b0;
        n_req[0] = 1;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) n_req[1] = 1;
            cycle(g, r, sv, sa, ro);
            checks++;
            if (sv !== 1'b1 || sa !== 32'h1000) begin errors++; $display("FAIL lock_stall_addr[%0d]: got req=%0b addr=%h, expected req=1 addr=00001000", k, sv, sa); end
            checks++;
            if (g != -1) begin errors++; $display("FAIL lock_stall_gnt[%0d]: got %0d, expected -1", k, g); end
        end
        ram_gnt = 1'b1;
        expect_resp(0); cycle(g, r, sv, sa, ro);
        checks++; if (g != 0) begin errors++; $display("FAIL lock_grant_m0: got %0d, expected 0", g); end
        expect_resp(1); cycle(g, r, sv, sa, ro);
        checks++; if (g != 1) begin errors++; $display("FAIL lock_grant_m1: got %0d, expected 1", g); end
        // rr now points at master2: the stalled master0 request must stay pinned when master2 arrives
        ram_gnt  = 1'b0;
        n_req[0] = 1;
        cycle(g, r, sv, sa, ro);
        n_req[2] = 1;
        cycle(g, r, sv, sa, ro);
        checks++; if (sa !== 32'h1000) begin errors++; $display("FAIL lock_hold_addr: got %h, expected 00001000", sa); end
        ram_gnt = 1'b1;
        expect_resp(0); cycle(g, r, sv, sa, ro);
        checks++; if (g != 0) begin errors++; $display("FAIL lock_hold_grant: got %0d, expected 0", g); end
        expect_resp(2); cycle(g, r, sv, sa, ro);
        checks++; if (g != 2) begin errors++; $display("FAIL lock_next_grant: got %0d, expected 2", g); end
        drain();
        checks++;
        if (obs.size() != sb.size()) begin errors++; $display("FAIL lock_resp_count: got %0d, expected %0d", obs.size(), sb.size()); end
        while (sb.size() > 0 && obs.size() > 0) begin
            resp_rec_t e = sb.pop_front();
            resp_rec_t o = obs.pop_front();
            checks++;
            if (o.idx != e.idx || o.data !== e.data) begin
                errors++; $display("FAIL lock_resp: got m%0d %h, expected m%0d %h", o.idx, o.data, e.idx, e.data);
            end
        end
        sb.delete(); obs.delete();
    endtask

    task automatic test_full();
        n_req[0] = 3;
        ram_gnt  = 1'b1;
        rv_hold  = 1'b1;
        expect_resp(0); cycle(g, r, sv, sa, ro);
        checks++; if (g != 0) begin errors++; $display("FAIL full_grant1: got %0d, expected 0", g); end
        expect_resp(0); cycle(g, r, sv, sa, ro);
        checks++; if (g != 0) begin errors++; $display("FAIL full_grant2: got %0d, expected 0", g); end
        cycle(g, r, sv, sa, ro);
        checks++; if (sv !== 1'b0 || g != -1) begin errors++; $display("FAIL full_block: got req=%0b gnt=%0d, expected req=0 gnt=-1", sv, g); end
        rv_hold = 1'b0;
        cycle(g, r, sv, sa, ro);
        checks++; if (sv !== 1'b0) begin errors++; $display("FAIL full_block2: got req=%0b, expected 0", sv); end
        cycle(g, r, sv, sa, ro);
        checks++; if (r != 0) begin errors++; $display("FAIL full_rvalid: got %0d, expected 0", r); end
        checks++; if (sv !== 1'b0 || g != -1) begin errors++; $display("FAIL full_rvalid_cycle: got req=%0b gnt=%0d, expected req=0 gnt=-1", sv, g); end
        expect_resp(0); cycle(g, r, sv, sa, ro);
        checks++; if (g != 0) begin errors++; $display("FAIL full_grant3: got %0d, expected 0", g); end
        drain();
        checks++;
        if (obs.size() != sb.size()) begin errors++; $display("FAIL full_resp_count: got %0d, expected %0d", obs.size(), sb.size()); end
        while (sb.size() > 0 && obs.size() > 0) begin
            resp_rec_t e = sb.pop_front();
            resp_rec_t o = obs.pop_front();
            checks++;
            if (o.idx != e.idx || o.data !== e.data) begin
                errors++; $display("FAIL full_resp: got m%0d %h, expected m%0d %h", o.idx, o.data, e.idx, e.data);
            end
        end
        sb.delete(); obs.delete();
    endtask

    task automatic test_simultaneous();
        n_req[1] = 1;
        ram_gnt  = 1'b1;
        rv_hold  = 1'b0;
        expect_resp(1); cycle(g, r, sv, sa, ro);
        checks++; if (g != 1) begin errors++; $display("FAIL simul_grant1: got %0d, expected 1", g); end
        n_req[2] = 1;
        rv_hold  = 1'b1;
        expect_resp(2); cycle(g, r, sv, sa, ro);
        checks++; if (r != 1) begin errors++; $display("FAIL simul_rvalid_old: got %0d, expected 1", r); end
        checks++; if (g != 2) begin errors++; $display("FAIL simul_grant2: got %0d, expected 2", g); end
        // one slot left if the occupancy held at 1 across the push+pop cycle
        n_req[0] = 2;
        expect_resp(0); cycle(g, r, sv, sa, ro);
        checks++; if (g != 0) begin errors++; $display("FAIL simul_grant3: got %0d, expected 0", g); end
        cycle(g, r, sv, sa, ro);
        checks++; if (sv !== 1'b0) begin errors++; $display("FAIL simul_full: got req=%0b, expected 0", sv); end
        drain();
        checks++;
        if (obs.size() != sb.size()) begin errors++; $display("FAIL simul_resp_count: got %0d, expected %0d", obs.size(), sb.size()); end
        while (sb.size() > 0 && obs.size() > 0) begin
            resp_rec_t e = sb.pop_front();
            resp_rec_t o = obs.pop_front();
            checks++;
            if (o.idx != e.idx || o.data !== e.data) begin
                errors++; $display("FAIL simul_resp: got m%0d %h, expected m%0d %h", o.idx, o.data, e.idx, e.data);
            end
        end
        sb.delete(); obs.delete();
    endtask

    task automatic test_reset_mid();
        n_req[1] = 2;
        ram_gnt  = 1'b1;
        rv_hold  = 1'b1;
        cycle(g, r, sv, sa, ro);
        cycle(g, r, sv, sa, ro);
        checks++; if (g != 1) begin errors++; $display("FAIL rmid_setup: got %0d, expected 1", g); end
        n_req[1] = 0;
        rst      = 1'b1;
        cycle(g, r, sv, sa, ro);
        sresp.rvalid = 1'b1;
        sresp.rdata  = 32'hDEAD_BEEF;
        cycle(g, r, sv, sa, ro);
        checks++; if (r != -1) begin errors++; $display("FAIL rmid_late_rvalid: got %0d, expected -1", r); end
        checks++; if (sv !== 1'b0 || g != -1 || ro !== 32'h0) begin errors++; $display("FAIL rmid_outputs: got req=%0b gnt=%0d rdata=%h, expected 0/-1/0", sv, g, ro); end
        rst = 1'b0;
        pending.delete();
        sresp.rvalid = 1'b0;
        sresp.rdata  = 32'h0;
        n_req[0] = 3;
        expect_resp(0); cycle(g, r, sv, sa, ro);
        checks++; if (g != 0) begin errors++; $display("FAIL rmid_post_grant1: got %0d, expected 0", g); end
        expect_resp(0); cycle(g, r, sv, sa, ro);
        checks++; if (g != 0) begin errors++; $display("FAIL rmid_post_grant2: got %0d, expected 0", g); end
        cycle(g, r, sv, sa, ro);
        checks++; if (sv !== 1'b0) begin errors++; $display("FAIL rmid_post_full: got req=%0b, expected 0", sv); end
        drain();
        checks++;
        if (obs.size() != sb.size()) begin errors++; $display("FAIL rmid_resp_count: got %0d, expected %0d", obs.size(), sb.size()); end
        while (sb.size() > 0 && obs.size() > 0) begin
            resp_rec_t e = sb.pop_front();
            resp_rec_t o = obs.pop_front();
            checks++;
            if (o.idx != e.idx || o.data !== e.data) begin
                errors++; $display("FAIL rmid_resp: got m%0d %h, expected m%0d %h", o.idx, o.data, e.idx, e.data);
            end
        end
        sb.delete(); obs.delete();
    endtask

    task automatic test_back_to_back();
        int exp_g [5] = '{0, 1, 2, 2, 2};
        n_req[2] = 4;
        ram_gnt  = 1'b1;
        rv_hold  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            expect_resp(2);
            cycle(g, r, sv, sa, ro);
            checks++;
            if (g != 2) begin errors++; $display("FAIL b2b_solo[%0d]: got %0d, expected 2", k, g); end
        end
        n_req[0] = 1;
        n_req[1] = 1;
        n_req[2] = 3;
        for (int k = 0; k < 5; k++) begin
            expect_resp(exp_g[k]);
            cycle(g, r, sv, sa, ro);
            checks++;
            if (g != exp_g[k]) begin errors++; $display("FAIL b2b_join[%0d]: got %0d, expected %0d", k, g, exp_g[k]); end
        end
        drain();
        checks++;
        if (obs.size() != sb.size()) begin errors++; $display("FAIL b2b_resp_count: got %0d, expected %0d", obs.size(), sb.size()); end
        while (sb.size() > 0 && obs.size() > 0) begin
            resp_rec_t e = sb.pop_front();
            resp_rec_t o = obs.pop_front();
            checks++;
            if (o.idx != e.idx || o.data !== e.data) begin
                errors++; $display("FAIL b2b_resp: got m%0d %h, expected m%0d %h", o.idx, o.data, e.idx, e.data);
            end
        end
        sb.delete(); obs.delete();
    endtask

    initial begin
        rst   = 1'b1;
        mreq  = '0;
        sresp = '0;
        test_reset();
        test_round_robin();
        test_lock();
        test_full();
        test_simultaneous();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/mochila_ram_arbiter.md
Name: mochila_ram_arbiter

Overview:
- OBI N:1 arbiter that shares the single memory_sys RAM port among the core data ports and the external master.
- Round-robin grant among requesters, with a request lock held until grant.
- An in-order response-routing FIFO returns each rvalid/rdata to the master that issued the request.
- Sits inside bus_system, between the crossbar RAM-bound master ports and ram_req_o/ram_resp_i.

Parameters:
- NMASTERS, 3, number of requesting OBI masters (2 cores + ext master); range 2..8.
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered transactions (routing FIFO depth); range 1..8.
- IDX_W, $clog2(NMASTERS), derived localparam, master index width.

Ports:
- clk_i  in  1  single clock.
- rst_i  in  1  synchronous reset, active-high.
- master_req_i  in  NMASTERS x obi_req_t  per-master req, addr, we, be, wdata.
- master_resp_o  out  NMASTERS x obi_resp_t  per-master gnt, rvalid, rdata.
- slave_req_o  out  obi_req_t  to RAM.
- slave_resp_i  in  obi_resp_t  from RAM.

Behaviour:
- Reset (rst_i=1 at a clk_i edge):
  - rr_ptr=0, lock_valid=0, lock_idx=0.
  - FIFO count=0, wr_ptr=0, rd_ptr=0.
  - Outputs: all master gnt/rvalid=0, rdata=0, slave_req_o.req=0.
  - Reset mid-transaction discards all FIFO contents. Any RAM rvalid arriving afterwards is dropped.
- Selection (combinational):
  - If lock_valid, winner=lock_idx.
  - Else winner = first master with req=1, scanning rr_ptr, rr_ptr+1, ... modulo NMASTERS.
  - No requester => slave_req_o.req=0.
- Forwarding:
  - slave_req_o.{addr,we,be,wdata} = winner fields.
  - slave_req_o.req = winner.req AND (count < MAX_OUTSTANDING).
- Grant:
  - master_resp_o[winner].gnt = slave_resp_i.gnt AND slave_req_o.req.
  - All other gnt=0. Zero added latency on the req->gnt path.
- Lock:
  - If slave_req_o.req=1 and gnt=0, next cycle lock_valid=1, lock_idx=winner.
  - Lock clears in the cycle gnt arrives.
  - While locked, winner cannot change even if higher-priority requests appear.
- Round-robin update: on an accepted handshake (req&gnt), rr_ptr <= (winner+1) mod NMASTERS. Otherwise rr_ptr holds.
- FIFO push: on an accepted handshake, push winner index.
- FIFO pop:
  - On slave_resp_i.rvalid with count>0, pop the head.
  - master_resp_o[head].rvalid=1 and rdata=slave_resp_i.rdata in that same cycle (combinational, 0 latency).
  - Other masters: rvalid=0, rdata=0.
- Simultaneous push and pop: count unchanged, both pointers advance. Valid at count=MAX_OUTSTANDING-1 and below.
- Full (count=MAX_OUTSTANDING):
  - slave_req_o.req forced 0, even if rvalid arrives in the same cycle. This registered-style conservatism is decided.
  - Lock is not set while req is suppressed by full.
- Pointer wrap: wr_ptr and rd_ptr wrap modulo MAX_OUTSTANDING. count is kept separately (width $clog2(MAX_OUTSTANDING+1)).
- Error case: rvalid with count=0 is dropped and no master sees rvalid. A simulation-only assertion flags it.
- Ordering: responses are strictly in grant order. RAM is required to respond in order.

Test Plan:
- Reset, then all three masters req continuously, RAM gnt=1 each cycle, rvalid 1 cycle later -> grants go to 0,1,2,0,1,2. Each rvalid is routed to the matching master. rdata=addr pattern 0x100+idx is returned correctly.
- RAM stalls gnt=0 for 3 cycles while master0 requests and master1 asserts req in cycle 2 -> slave_req_o stays on master0's addr 0x1000 until gnt. master1 is granted next.
- MAX_OUTSTANDING=2, RAM gnt=1 but rvalid withheld -> 2 grants are accepted, then slave_req_o.req=0. One rvalid re-enables req the following cycle. A third grant occurs, and no grant occurs in the rvalid cycle itself.
- Simultaneous grant+rvalid at count=1 -> count stays 1. Response goes to the older master, and the new index is queued behind it.
- rst_i asserted with count=2 -> next cycle all outputs are 0 and count=0. A late RAM rvalid is dropped, and the assertion does not fire during reset.
- Single requester master2 issuing back-to-back requests -> granted every cycle. rr_ptr alternates to 0 after each handshake, with no starvation for masters 0 and 1 when they join later.
